// File: rtl/fetch_unit.sv
// fetch_unit -- RV32I instruction fetch stage.
//
// Samples the PC at each launch, issues one outstanding request to
// instruction memory, and queues the returned {pc, instruction} pairs in a
// small FIFO for decode. pc_ready tells the PC register to advance on the
// same edge that the fetch is launched. A flush discards buffered entries
// and any fetch still in flight.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When it is defined, a launch
// with pc_in[1:0] != 0 issues no memory request. Instead it queues a NOP
// marked as a misaligned-address fault.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   pc_in / pc_ready       current PC in, PC advance enable out
//   imem_req / imem_addr   memory request (held until ack) and its address
//   imem_ack / imem_rdata  one-cycle response strobe and instruction
//   flush                  redirect: drop buffered and in-flight fetches
//   id_valid / id_ready    FIFO head handshake toward decode
//   id_inst / id_pc        head instruction and its PC
//   id_fault               head is a misaligned-fetch fault
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_ready,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  flush,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic                  id_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state_q;
  logic                    imem_req_q;
  logic [ADDR_WIDTH-1:0]   imem_addr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;

  logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]   inst_mem [DEPTH];

  logic                    launch, misalign, launch_fetch;
  logic                    push, pop;
  logic [ADDR_WIDTH-1:0]   push_pc;
  logic [DATA_WIDTH-1:0]   push_inst;

  // Launch is only possible with room in the FIFO. Since only one fetch is
  // ever outstanding, an ack can never push into a full FIFO.
  assign launch   = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !flush;
  assign pc_ready = launch;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign = launch && (pc_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign launch_fetch = launch && !misalign;

  // A flush that coincides with the ack discards the returned data.
  assign push      = ((state_q == WAIT) && imem_ack && !flush) || misalign;
  assign push_pc   = misalign ? pc_in : imem_addr_q;
  assign push_inst = misalign ? DATA_WIDTH'(32'h0000_0013) : imem_rdata;

  assign id_valid  = (count_q != '0);
  assign pop       = id_valid && id_ready && !flush;

  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Request FSM. In DROP the request remains held until the memory answers,
  // because the memory has no way to cancel an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_fetch) begin
            imem_addr_q <= pc_in;
            imem_req_q  <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end else if (flush) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Entry storage needs no reset because id_* are masked while the FIFO is
  // empty. A write that coincides with a flush is harmless: the pointers
  // are reset at the same edge, so the entry is never read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      inst_mem[wr_ptr_q] <= push_inst;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign id_pc     = id_valid ? pc_mem[rd_ptr_q]   : '0;
  assign id_inst   = id_valid ? inst_mem[rd_ptr_q] : '0;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) fault_mem[wr_ptr_q] <= misalign;
  end

  assign id_fault = id_valid ? fault_mem[rd_ptr_q] : 1'b0;
`else
  assign id_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change at the negedge. pc_ready is
// checked just after that negedge, and registered outputs 1 ns after the
// posedge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_ready   (pc_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_fault   (id_fault)
  );

  // One row per clock cycle. e_pcr is pc_ready before the edge. The other
  // expected fields are the outputs after the edge.
  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        fl;
    logic        rdy;
    logic        e_pcr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pc, input logic ack, input logic [31:0] rdata,
                     input logic fl, input logic rdy, input logic e_pcr, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.pc = pc; v.ack = ack; v.rdata = rdata; v.fl = fl; v.rdy = rdy;
    v.e_pcr = e_pcr; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_inst = e_inst;
    tbl.push_back(v);
  endtask

  initial begin
    logic got;

    // Fetch at 0x0 with one-cycle ack and decode ready.
    add(32'h000, 1, 32'h0,          0, 1,  1, 1, 32'h000, 0, 32'h000, 32'h0);
    add(32'h004, 1, 32'h0050_0093,  0, 1,  0, 0, 32'h000, 1, 32'h000, 32'h0050_0093);
    add(32'h004, 0, 32'h0,          0, 1,  1, 1, 32'h004, 0, 32'h000, 32'h0);
    // Decode stalls. Two entries fill the FIFO.
    add(32'h008, 1, 32'h0010_8113,  0, 0,  0, 0, 32'h004, 1, 32'h004, 32'h0010_8113);
    add(32'h008, 0, 32'h0,          0, 0,  1, 1, 32'h008, 1, 32'h004, 32'h0010_8113);
    add(32'h00C, 1, 32'h0020_8193,  0, 0,  0, 0, 32'h008, 1, 32'h004, 32'h0010_8113);
    add(32'h00C, 0, 32'h0,          0, 0,  0, 0, 32'h008, 1, 32'h004, 32'h0010_8113);
    add(32'h00C, 0, 32'h0,          0, 0,  0, 0, 32'h008, 1, 32'h004, 32'h0010_8113);
    // Pop in order, then fetching resumes.
    add(32'h00C, 0, 32'h0,          0, 1,  0, 0, 32'h008, 1, 32'h008, 32'h0020_8193);
    add(32'h00C, 0, 32'h0,          0, 0,  1, 1, 32'h00C, 1, 32'h008, 32'h0020_8193);
    // Flush in WAIT. The ack arrives three cycles later and is dropped.
    add(32'h00C, 0, 32'h0,          1, 0,  0, 1, 32'h00C, 0, 32'h000, 32'h0);
    add(32'h100, 0, 32'h0,          0, 0,  0, 1, 32'h00C, 0, 32'h000, 32'h0);
    add(32'h100, 0, 32'h0,          0, 0,  0, 1, 32'h00C, 0, 32'h000, 32'h0);
    add(32'h100, 1, 32'hDEAD_BEEF,  0, 0,  0, 0, 32'h00C, 0, 32'h000, 32'h0);
    add(32'h100, 0, 32'h0,          0, 1,  1, 1, 32'h100, 0, 32'h000, 32'h0);
    // Flush and ack on the same edge.
    add(32'h104, 1, 32'h1111_1111,  1, 1,  0, 0, 32'h100, 0, 32'h000, 32'h0);
    add(32'h104, 0, 32'h0,          0, 0,  1, 1, 32'h104, 0, 32'h000, 32'h0);
    add(32'h108, 1, 32'h2222_2222,  0, 0,  0, 0, 32'h104, 1, 32'h104, 32'h2222_2222);
    add(32'h108, 0, 32'h0,          0, 0,  1, 1, 32'h108, 1, 32'h104, 32'h2222_2222);
    add(32'h10C, 1, 32'h3333_3333,  0, 0,  0, 0, 32'h108, 1, 32'h104, 32'h2222_2222);
    // Flush with the FIFO full overrides the pop. Flush also blocks a launch.
    add(32'h10C, 0, 32'h0,          1, 1,  0, 0, 32'h108, 0, 32'h000, 32'h0);
    add(32'h200, 0, 32'h0,          1, 0,  0, 0, 32'h108, 0, 32'h000, 32'h0);
    add(32'h200, 0, 32'h0,          0, 1,  1, 1, 32'h200, 0, 32'h000, 32'h0);
    add(32'h204, 1, 32'h4444_4444,  0, 1,  0, 0, 32'h200, 1, 32'h200, 32'h4444_4444);
    // Pop and launch in the same cycle.
    add(32'h204, 0, 32'h0,          0, 1,  1, 1, 32'h204, 0, 32'h000, 32'h0);
    add(32'h208, 1, 32'h5555_5555,  0, 0,  0, 0, 32'h204, 1, 32'h204, 32'h5555_5555);
    add(32'h208, 0, 32'h0,          0, 0,  1, 1, 32'h208, 1, 32'h204, 32'h5555_5555);

    // Reset.
    rst = 1'b1; pc_in = '0; imem_ack = 1'b0; imem_rdata = '0; flush = 1'b1; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_pc",    id_pc,             32'h0);
    chk("rst_inst",  id_inst,           32'h0);
    chk("rst_fault", {31'b0, id_fault}, 32'h0);
    $display("reset: req=%b addr=%h valid=%b", imem_req, imem_addr, id_valid);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      pc_in = tbl[i].pc; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      flush = tbl[i].fl; id_ready = tbl[i].rdy;
      #1;
      chk($sformatf("r%0d_pc_ready", i), {31'b0, pc_ready}, {31'b0, tbl[i].e_pcr});
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("r%0d_addr", i),  imem_addr,         tbl[i].e_addr);
      chk($sformatf("r%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("r%0d_id_pc", i),   id_pc,             tbl[i].e_pc);
        chk($sformatf("r%0d_id_inst", i), id_inst,           tbl[i].e_inst);
        chk($sformatf("r%0d_id_fault", i), {31'b0, id_fault}, 32'h0);
      end
      $display("row %0d: pc_in=%h ack=%b flush=%b rdy=%b -> req=%b addr=%h valid=%b id_pc=%h id_inst=%h",
               i, tbl[i].pc, tbl[i].ack, tbl[i].fl, tbl[i].rdy, imem_req, imem_addr,
               id_valid, id_pc, id_inst);
    end

    // Asynchronous reset mid-WAIT with one entry buffered.
    #2 rst = 1'b1;
    #1;
    chk("arst_req",   {31'b0, imem_req}, 32'h0);
    chk("arst_addr",  imem_addr,         32'h0);
    chk("arst_valid", {31'b0, id_valid}, 32'h0);
    chk("arst_id_pc", id_pc,             32'h0);
    $display("async reset mid-WAIT: req=%b addr=%h valid=%b", imem_req, imem_addr, id_valid);
    @(posedge clk);
    #1;
    chk("arst_hold_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0; pc_in = 32'h300; imem_ack = 1'b0; flush = 1'b0; id_ready = 1'b0;
    #1;
    chk("post_rst_pc_ready", {31'b0, pc_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_req",  {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr,         32'h300);
    @(negedge clk);
    pc_in = 32'h304; imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
    @(negedge clk);
    imem_ack = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (id_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("post_rst_wait_valid", {31'b0, got}, 32'h1);
    chk("post_rst_id_pc",      id_pc,        32'h300);
    chk("post_rst_id_inst",    id_inst,      32'h6666_6666);
    $display("post-reset fetch: valid=%b id_pc=%h id_inst=%h", id_valid, id_pc, id_inst);
    flush = 1'b1;
    @(posedge clk);
    #1;

`ifdef FETCH_MISALIGN_CHK_EN
    // A misaligned PC produces a fault entry and no memory request.
    wait (imem_req == 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; pc_in = 32'h102; imem_ack = 1'b0; id_ready = 1'b0;
    #1;
    chk("mis_pc_ready", {31'b0, pc_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("mis_req",   {31'b0, imem_req}, 32'h0);
    chk("mis_valid", {31'b0, id_valid}, 32'h1);
    chk("mis_fault", {31'b0, id_fault}, 32'h1);
    chk("mis_id_pc", id_pc,             32'h102);
    chk("mis_inst",  id_inst,           32'h0000_0013);
    $display("misaligned 0x102: req=%b valid=%b fault=%b id_pc=%h id_inst=%h",
             imem_req, id_valid, id_fault, id_pc, id_inst);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
